// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain stream loader.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_VERIFY = 2'd2
   } ccff_ld_state_e;

   // Number of bitstream words needed to cover a chain: ceil(chainLen / wordW).
   function automatic int ccff_words(input int chainLen, input int wordW);
      return (chainLen + wordW - 1) / wordW;
   endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Readback collector: packs strobed tail bits MSB-first into words and hands
// them to a single holding register with a valid/ready output.
module ccff_rb_packer #(
   parameter int WORD_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_bit,
   input  logic              i_strobe,
   input  logic              i_last,
   input  logic              i_rbReady,
   output logic              o_colFull,
   output logic [WORD_W-1:0] o_rbData,
   output logic              o_rbValid
);

   localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [WORD_W-1:0] MSB_ONE = WORD_W'(1) << (WORD_W - 1);

   logic [WORD_W-1:0] r_col;
   logic [CNT_W-1:0]  r_colCnt;
   logic              r_colFull;
   logic [WORD_W-1:0] r_rbData;
   logic              r_rbValid;

   logic [WORD_W-1:0] w_colNext;
   logic              w_complete;
   logic              w_holdFree;

   // Merge the incoming bit into the collector and decide whether this bit closes the word.
   always_comb begin
      w_colNext  = r_col;
      w_complete = 1'b0;
      w_holdFree = !r_rbValid || i_rbReady;
      if (i_strobe) begin
         w_colNext  = r_col | (i_bit ? (MSB_ONE >> r_colCnt) : '0);
         w_complete = (r_colCnt == CNT_W'(WORD_W - 1)) || i_last;
      end
   end

   // A completed word goes straight to the holding register when it is free;
   // otherwise it parks in the collector (colFull) until the consumer drains.
   // The top never strobes while colFull with the holding register occupied.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_col     <= '0;
         r_colCnt  <= '0;
         r_colFull <= 1'b0;
         r_rbData  <= '0;
         r_rbValid <= 1'b0;
      end else begin
         if (w_complete) begin
            r_colCnt <= '0;
            if (w_holdFree) begin
               r_rbData  <= w_colNext;
               r_rbValid <= 1'b1;
               r_col     <= '0;
            end else begin
               r_col     <= w_colNext;
               r_colFull <= 1'b1;
            end
         end else if (r_colFull && w_holdFree) begin
            r_rbData  <= r_col;
            r_rbValid <= 1'b1;
            r_colFull <= 1'b0;
            r_col     <= '0;
         end else begin
            if (i_strobe) begin
               r_col    <= w_colNext;
               r_colCnt <= r_colCnt + CNT_W'(1);
            end
            if (r_rbValid && i_rbReady) begin
               r_rbValid <= 1'b0;
            end
         end
      end
   end

   assign o_colFull = r_colFull;
   assign o_rbData  = r_rbData;
   assign o_rbValid = r_rbValid;

endmodule

// File: rtl/ccff_stream_loader.sv
// Configuration-chain front end: serialises a word stream onto ccff_head with a
// matching shift enable for the gated prog_clk, and performs a recirculating
// readback that leaves the chain contents intact.
module ccff_stream_loader
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 20
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              cmd_load,
   input  logic              cmd_verify,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   input  logic              rb_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              chain_shift_en,
   output logic              busy,
   output logic              done,
   output logic              cmd_err
);

   localparam int CW     = $clog2(CHAIN_LEN + 1);
   localparam int BW     = $clog2(WORD_W + 1);
   localparam int NWORDS = ccff_words(CHAIN_LEN, WORD_W);

   ccff_ld_state_e    r_state;
   logic [WORD_W-1:0] r_sh;
   logic [BW-1:0]     r_bufBits;
   logic [CW-1:0]     r_bitsRem;
   logic [CW-1:0]     r_wordsRem;
   logic              r_done;
   logic              r_cmdErr;

   logic              w_isLoad;
   logic              w_isVerify;
   logic              w_loadShift;
   logic              w_verShift;
   logic              w_colFull;
   logic              w_holdFree;
   logic              w_accept;
   logic              w_vLast;
   logic              w_verDone;
   logic              w_cmd;
   logic [CW-1:0]     w_bitsRemAfter;
   logic [BW-1:0]     w_bufLoad;

   // Shift qualification, head mux and bitstream handshake for the current state.
   always_comb begin
      w_isLoad       = (r_state == ST_LOAD);
      w_isVerify     = (r_state == ST_VERIFY);
      w_cmd          = cmd_load || cmd_verify;
      w_holdFree     = !rb_valid || rb_ready;
      w_vLast        = (r_bitsRem == CW'(1));
      w_loadShift    = w_isLoad && (r_bufBits != '0);
      w_verShift     = w_isVerify && (r_bitsRem != '0) && !(w_colFull && rb_valid);
      chain_shift_en = w_loadShift || w_verShift;
      ccff_head      = 1'b0;
      if (w_isLoad) begin
         ccff_head = r_sh[WORD_W-1];
      end else if (w_isVerify) begin
         ccff_head = ccff_tail;
      end
      bs_ready = w_isLoad && (r_wordsRem != '0) &&
                 ((r_bufBits == '0) || ((r_bufBits == BW'(1)) && w_loadShift));
      w_accept = bs_valid && bs_ready;
      w_bitsRemAfter = (chain_shift_en && (r_bitsRem != '0)) ? (r_bitsRem - CW'(1)) : r_bitsRem;
      if (int'(w_bitsRemAfter) >= WORD_W) begin
         w_bufLoad = BW'(WORD_W);
      end else begin
         w_bufLoad = BW'(w_bitsRemAfter);
      end
      w_verDone = w_isVerify &&
                  ((w_verShift && w_vLast && w_holdFree) ||
                   ((r_bitsRem == '0) && w_colFull && w_holdFree));
   end

   // Command sequencing, load shift register and bit/word bookkeeping.
   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         r_state    <= ST_IDLE;
         r_sh       <= '0;
         r_bufBits  <= '0;
         r_bitsRem  <= '0;
         r_wordsRem <= '0;
         r_done     <= 1'b0;
         r_cmdErr   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cmd) begin
                  r_state    <= cmd_load ? ST_LOAD : ST_VERIFY;
                  r_bitsRem  <= CW'(CHAIN_LEN);
                  r_wordsRem <= CW'(NWORDS);
                  r_bufBits  <= '0;
                  r_done     <= 1'b0;
                  r_cmdErr   <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (w_cmd) begin
                  r_cmdErr <= 1'b1;
               end
               if (w_accept) begin
                  r_sh       <= bs_data;
                  r_bufBits  <= w_bufLoad;
                  r_wordsRem <= r_wordsRem - CW'(1);
               end else if (w_loadShift) begin
                  r_sh      <= r_sh << 1;
                  r_bufBits <= r_bufBits - BW'(1);
               end
               if (w_loadShift) begin
                  r_bitsRem <= w_bitsRemAfter;
                  if (r_bitsRem == CW'(1)) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_VERIFY: begin
               if (w_cmd) begin
                  r_cmdErr <= 1'b1;
               end
               if (w_verShift) begin
                  r_bitsRem <= w_bitsRemAfter;
               end
               if (w_verDone) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   ccff_rb_packer #(
      .WORD_W (WORD_W)
   ) u_packer (
      .i_clk     (prog_clk),
      .i_rst     (prog_reset),
      .i_bit     (ccff_tail),
      .i_strobe  (w_verShift),
      .i_last    (w_vLast),
      .i_rbReady (rb_ready),
      .o_colFull (w_colFull),
      .o_rbData  (rb_data),
      .o_rbValid (rb_valid)
   );

   assign busy    = (r_state != ST_IDLE);
   assign done    = r_done;
   assign cmd_err = r_cmdErr;

endmodule
